ctrl_sequencer: RTL and testbench

//  Instruction sequencer that drives the register load/select control bus (the initiator side).

---
 rtl/ctrl_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer -- instruction sequencer, initiator of the register load/select bus.
//
// Runs fetch -> PC increment -> execute for each instruction and issues one-hot
// load/select strobes on every cycle of the sequence. GOTO goes on to read two
// operand bytes into J1/J2 and then (conditionally) loads the PC from J.
//
// Ports:
//   clock     in   system clock, all state changes on its rising edge
//   reset     in   synchronous, active-high
//   run       in   level; a rising edge in HALT starts free-running execution
//   step      in   one-cycle pulse; in HALT executes exactly one instruction
//   inst[7:0] in   INST register contents
//   flags[2:0]in   {sign, carry, zero} from the ALU flag latch
//   loadsel   out  load/select strobe bus (bit map in the localparams below)
//   mem_read  out  memory drives the data bus
//   mem_write out  memory latches the data bus
//   alu_sel   out  ALU result driven onto the data bus
//   alu_fn    out  ALU function, inst[2:0] while alu_sel=1, else 0
//   halted    out  1 while in HALT
//   illegal   out  one-cycle pulse in EXEC of an undefined opcode
//
// Configuration macro: COND_BRANCH_EN
//   defined   -> GOTO taken iff mask==000 or (mask & flags)!=0, flags sampled in JMP
//   undefined -> every GOTO taken
module ctrl_sequencer #(
    parameter int CTRL_BUS_WIDTH = 26
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      step,
    input  logic [7:0]                inst,
    input  logic [2:0]                flags,
    output logic [CTRL_BUS_WIDTH-1:0] loadsel,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      alu_sel,
    output logic [2:0]                alu_fn,
    output logic                      halted,
    output logic                      illegal
);

    // Control bus bit positions.
    localparam int B_LDM1 = 8,  B_LDM2 = 9,  B_SELM1 = 10, B_SELM2 = 11;
    localparam int B_LDJ1 = 18, B_LDJ2 = 19, B_SELJ  = 20, B_LDINST = 21;
    localparam int B_LDPC = 22, B_SELPC = 23, B_LDINC = 24, B_SELINC = 25;

    typedef enum logic [3:0] {
        S_HALT, S_FETCH, S_INC, S_PCLD, S_EXEC,
        S_J1, S_J1I, S_J1P, S_J2, S_J2I, S_J2P, S_JMP
    } state_t;

    state_t r_state;
    logic   r_run_q;
    logic   r_one_shot;

    // Register code -> load / select strobe: 0 A 1 B 2 C 3 D 4 M1 5 M2 6 X 7 Y.
    function automatic logic [25:0] ld_mask(input logic [2:0] r);
        logic [25:0] m;
        m = '0;
        case (r)
            3'd0: m[0]      = 1'b1;
            3'd1: m[2]      = 1'b1;
            3'd2: m[4]      = 1'b1;
            3'd3: m[6]      = 1'b1;
            3'd4: m[B_LDM1] = 1'b1;
            3'd5: m[B_LDM2] = 1'b1;
            3'd6: m[12]     = 1'b1;
            default: m[13]  = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [25:0] sel_mask(input logic [2:0] r);
        logic [25:0] m;
        m = '0;
        case (r)
            3'd0: m[1]       = 1'b1;
            3'd1: m[3]       = 1'b1;
            3'd2: m[5]       = 1'b1;
            3'd3: m[7]       = 1'b1;
            3'd4: m[B_SELM1] = 1'b1;
            3'd5: m[B_SELM2] = 1'b1;
            3'd6: m[14]      = 1'b1;
            default: m[15]   = 1'b1;
        endcase
        return m;
    endfunction

    // Opcode classes.
    logic w_is_mov, w_is_alu, w_is_load, w_is_stor, w_is_halt, w_is_goto;
    assign w_is_mov  = (inst[7:6] == 2'b00);
    assign w_is_alu  = (inst[7:4] == 4'b1000);
    assign w_is_load = (inst[7:2] == 6'b100100);
    assign w_is_stor = (inst[7:2] == 6'b100110);
    assign w_is_halt = (inst == 8'b1010_1110);
    assign w_is_goto = (inst[7:6] == 2'b11) && (inst[2:0] == 3'b110);

    logic w_run_edge, w_stop, w_taken;
    assign w_run_edge = run & ~r_run_q;
    // Finish the current instruction, then stop if single-stepping or run was dropped.
    assign w_stop     = r_one_shot | ~run;

`ifdef COND_BRANCH_EN
    assign w_taken = (inst[5:3] == 3'b000) || ((inst[5:3] & flags) != 3'b000);
`else
    logic w_unused_flags;
    assign w_unused_flags = ^flags;
    assign w_taken        = 1'b1;
`endif

    // NOTE: state uses non-blocking assignments so every register updates from
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        // run_q keeps tracking run through reset, so a run level held across
        // reset is not mistaken for a fresh rising edge afterwards.
        r_run_q <= run;
        if (reset) begin
            r_state    <= S_HALT;
            r_one_shot <= 1'b0;
        end else begin
            case (r_state)
                S_HALT: begin
                    if (w_run_edge || step) begin
                        r_state    <= S_FETCH;
                        r_one_shot <= ~w_run_edge;   // run wins over step
                    end
                end
                S_FETCH: r_state <= S_INC;
                S_INC:   r_state <= S_PCLD;
                S_PCLD:  r_state <= S_EXEC;
                S_EXEC: begin
                    if (w_is_goto) begin
                        r_state <= S_J1;
                    end else begin
                        r_state    <= (w_is_halt || w_stop) ? S_HALT : S_FETCH;
                        r_one_shot <= 1'b0;
                    end
                end
                S_J1:  r_state <= S_J1I;
                S_J1I: r_state <= S_J1P;
                S_J1P: r_state <= S_J2;
                S_J2:  r_state <= S_J2I;
                S_J2I: r_state <= S_J2P;
                S_J2P: r_state <= S_JMP;
                S_JMP: begin
                    r_state    <= w_stop ? S_HALT : S_FETCH;
                    r_one_shot <= 1'b0;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Moore decode of the state (plus inst in EXEC, inst/flags in JMP).
    logic [25:0] w_ctrl;
    logic        w_mem_read, w_mem_write, w_alu_sel, w_illegal;

    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_ctrl      = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_alu_sel   = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ctrl[B_SELPC]  = 1'b1;
                w_ctrl[B_LDINST] = 1'b1;
                w_mem_read       = 1'b1;
            end
            S_INC, S_J1I, S_J2I: begin
                w_ctrl[B_SELPC] = 1'b1;
                w_ctrl[B_LDINC] = 1'b1;
            end
            S_PCLD, S_J1P, S_J2P: begin
                w_ctrl[B_SELINC] = 1'b1;
                w_ctrl[B_LDPC]   = 1'b1;
            end
            S_J1: begin
                w_ctrl[B_SELPC] = 1'b1;
                w_ctrl[B_LDJ1]  = 1'b1;
                w_mem_read      = 1'b1;
            end
            S_J2: begin
                w_ctrl[B_SELPC] = 1'b1;
                w_ctrl[B_LDJ2]  = 1'b1;
                w_mem_read      = 1'b1;
            end
            S_JMP: begin
                if (w_taken) begin
                    w_ctrl[B_SELJ] = 1'b1;
                    w_ctrl[B_LDPC] = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_is_mov) begin
                    // Same source and destination is a one-cycle NOP.
                    if (inst[5:3] != inst[2:0])
                        w_ctrl = ld_mask(inst[5:3]) | sel_mask(inst[2:0]);
                end else if (w_is_alu) begin
                    w_alu_sel = 1'b1;
                    w_ctrl    = ld_mask(inst[3] ? 3'd3 : 3'd0);
                end else if (w_is_load) begin
                    w_ctrl     = sel_mask(3'd4) | sel_mask(3'd5) | ld_mask({1'b0, inst[1:0]});
                    w_mem_read = 1'b1;
                end else if (w_is_stor) begin
                    w_ctrl      = sel_mask(3'd4) | sel_mask(3'd5) | sel_mask({1'b0, inst[1:0]});
                    w_mem_write = 1'b1;
                end else if (!w_is_halt && !w_is_goto) begin
                    w_illegal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    generate
        if (CTRL_BUS_WIDTH > 26) begin : g_wide
            assign loadsel = {{(CTRL_BUS_WIDTH-26){1'b0}}, w_ctrl};
        end else begin : g_narrow
            assign loadsel = w_ctrl[CTRL_BUS_WIDTH-1:0];
        end
    endgenerate

    assign mem_read  = w_mem_read;
    assign mem_write = w_mem_write;
    assign alu_sel   = w_alu_sel;
    assign alu_fn    = w_alu_sel ? inst[2:0] : 3'b000;
    assign halted    = (r_state == S_HALT);
    assign illegal   = w_illegal;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer. Each scenario task drives stimulus and
// compares the full output vector {loadsel, mem_read, mem_write, alu_sel,
// alu_fn, halted, illegal} cycle by cycle against hand-computed expectations.
module tb_ctrl_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [7:0]  inst;
    logic [2:0]  flags;
    logic [25:0] loadsel;
    logic        mem_read, mem_write, alu_sel, halted, illegal;
    logic [2:0]  alu_fn;

    int vectors     = 0;
    int miscompares = 0;

    ctrl_sequencer #(.CTRL_BUS_WIDTH(26)) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .inst      (inst),
        .flags     (flags),
        .loadsel   (loadsel),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_sel   (alu_sel),
        .alu_fn    (alu_fn),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    // Expected vectors: {loadsel[25:0], mem_read, mem_write, alu_sel, alu_fn[2:0], halted, illegal}
    localparam logic [33:0] E_HALT  = {26'h0000000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [33:0] E_IDLE  = {26'h0000000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [33:0] E_FETCH = {26'h0A00000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // selPC ldINST
    localparam logic [33:0] E_INC   = {26'h1800000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // selPC ldINC
    localparam logic [33:0] E_PCLD  = {26'h2400000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // selINC ldPC
    localparam logic [33:0] E_J1    = {26'h0840000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // selPC ldJ1
    localparam logic [33:0] E_J2    = {26'h0880000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // selPC ldJ2
    localparam logic [33:0] E_JMP   = {26'h0500000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // selJ ldPC
    localparam logic [33:0] E_MOVBA = {26'h0000006, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // ldB selA
    localparam logic [33:0] E_MOVDC = {26'h0000060, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // ldD selC
    localparam logic [33:0] E_ALU3A = {26'h0000001, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0}; // ldA, fn 3
    localparam logic [33:0] E_LOADB = {26'h0000C04, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}; // selM1 selM2 ldB
    localparam logic [33:0] E_STORC = {26'h0000C20, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0}; // selM1 selM2 selC
    localparam logic [33:0] E_ILL   = {26'h0000000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};

    function automatic logic [33:0] obs();
        return {loadsel, mem_read, mem_write, alu_sel, alu_fn, halted, illegal};
    endfunction

    // Leaves the DUT in FETCH of a single-stepped instruction.
    task automatic start_step();
        @(posedge clock); #1 step = 1'b1;
        @(posedge clock); #1 step = 1'b0;
    endtask

    // Leaves the DUT in FETCH of a free-running sequence (run held high).
    task automatic start_run();
        @(posedge clock); #1 run = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; inst = 8'h00; flags = 3'b000;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (obs() !== E_HALT) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", obs(), E_HALT);
        end
        // Reset held for two cycles starting in EXEC, with run still high.
        inst = 8'h08;
        start_run();
        repeat (3) @(posedge clock);    // INC, PCLD, EXEC
        #1 reset = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== E_HALT) begin
                miscompares++;
                $display("FAIL reset_mid_exec cyc %0d: got %h expected %h", i, obs(), E_HALT);
            end
            if (i == 1) reset = 1'b0;
        end
        run = 1'b0;
    endtask

    task automatic test_step_mov();
        logic [33:0] exp [6];
        exp = '{E_FETCH, E_INC, E_PCLD, E_MOVBA, E_HALT, E_HALT};
        inst = 8'b00_001_000;
        start_step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL step_mov cyc %0d: got %h expected %h", i, obs(), exp[i]);
            end
        end
    endtask

    // ALU then LOAD back to back; run dropped during the second FETCH.
    task automatic test_back_to_back();
        logic [33:0] exp [9];
        exp = '{E_FETCH, E_INC, E_PCLD, E_ALU3A, E_FETCH, E_INC, E_PCLD, E_LOADB, E_HALT};
        inst = 8'b1000_0011;
        start_run();
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", i, obs(), exp[i]);
            end
            if (i == 4) begin
                inst = 8'b1001_0001;
                run  = 1'b0;
            end
        end
    endtask

    // STOR C; run dropped in the EXEC cycle itself.
    task automatic test_run_stor();
        logic [33:0] exp [5];
        exp = '{E_FETCH, E_INC, E_PCLD, E_STORC, E_HALT};
        inst = 8'b1001_1010;
        start_run();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL run_stor cyc %0d: got %h expected %h", i, obs(), exp[i]);
            end
            if (i == 3) run = 1'b0;
        end
    endtask

    // run and step rise together: run wins, execution keeps going.
    task automatic test_run_and_step();
        logic [33:0] exp [9];
        exp = '{E_FETCH, E_INC, E_PCLD, E_MOVDC, E_FETCH, E_INC, E_PCLD, E_MOVDC, E_HALT};
        inst = 8'b00_011_010;
        @(posedge clock); #1 run = 1'b1; step = 1'b1;
        @(posedge clock); #1 step = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL run_and_step cyc %0d: got %h expected %h", i, obs(), exp[i]);
            end
            if (i == 4) run = 1'b0;
        end
    endtask

    task automatic test_halt_op();
        logic [33:0] exp [6];
        exp = '{E_FETCH, E_INC, E_PCLD, E_IDLE, E_HALT, E_HALT};
        inst = 8'b1010_1110;
        start_run();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL halt_op cyc %0d: got %h expected %h", i, obs(), exp[i]);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_illegal_nop();
        logic [33:0] exp [5];
        exp = '{E_FETCH, E_INC, E_PCLD, E_ILL, E_HALT};
        inst = 8'hFF;
        start_step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL illegal cyc %0d: got %h expected %h", i, obs(), exp[i]);
            end
        end
        exp = '{E_FETCH, E_INC, E_PCLD, E_IDLE, E_HALT};
        inst = 8'b00_001_001;   // MOV B<-B: NOP
        start_step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL mov_nop cyc %0d: got %h expected %h", i, obs(), exp[i]);
            end
        end
    endtask

    // Single-stepped GOTO: 11 cycles then HALT; exp_jmp is the JMP-cycle vector.
    task automatic test_goto(input logic [7:0] op, input logic [2:0] fl,
                             input logic [33:0] exp_jmp, input string name);
        logic [33:0] exp [12];
        exp = '{E_FETCH, E_INC, E_PCLD, E_IDLE, E_J1, E_INC, E_PCLD,
                E_J2, E_INC, E_PCLD, exp_jmp, E_HALT};
        inst  = op;
        flags = fl;
        start_step();
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got %h expected %h", name, i, obs(), exp[i]);
            end
        end
        flags = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_step_mov();
        test_back_to_back();
        test_run_stor();
        test_run_and_step();
        test_halt_op();
        test_illegal_nop();
        test_goto(8'b11_000_110, 3'b000, E_JMP, "goto_uncond");
`ifdef COND_BRANCH_EN
        test_goto(8'b11_010_110, 3'b000, E_IDLE, "goto_cond_nf");
        test_goto(8'b11_010_110, 3'b001, E_IDLE, "goto_cond_other");
`else
        test_goto(8'b11_010_110, 3'b000, E_JMP, "goto_cond_nf");
        test_goto(8'b11_010_110, 3'b001, E_JMP, "goto_cond_other");
`endif
        test_goto(8'b11_010_110, 3'b010, E_JMP, "goto_cond_carry");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
